// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : disp_pkg
//  Purpose  : Shared constants for the four-digit seven-segment scanner:
//             digit count, active-low hex segment patterns {g,f,e,d,c,b,a},
//             the all-segments-off pattern and a small anode helper.
//  Revision : 1.0  initial release
// ============================================================================
package disp_pkg;

    localparam int DIGIT_COUNT = 4;

    typedef logic [1:0] digit_idx_t;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    localparam logic [DIGIT_COUNT-1:0] ANODES_OFF = '1;

    // Active-low anode vector with only the selected digit enabled
    function automatic logic [DIGIT_COUNT-1:0] anode_select(input digit_idx_t idx);
        logic [DIGIT_COUNT-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return ~onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_hex_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : disp_hex_decoder
//  Purpose  : Combinational 4-bit hex to active-low seven-segment decoder.
//  Revision : 1.0  initial release
// ============================================================================
module disp_hex_decoder
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Standard hex glyph lookup
    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/disp_sevenseg.sv
`default_nettype none
// ============================================================================
//  Module   : disp_sevenseg
//  Purpose  : Four-digit multiplexed seven-segment driver. A prescaler sets
//             the time per digit slot; the first BLANK_CYCLES of every slot
//             keep all anodes off to suppress ghosting. Inputs are captured
//             once per frame so a frame never shows a mix of old/new values.
//  Options  : DISP_LEADING_ZERO_BLANK_EN - blank leading zero digits
//             (digit 0 always shown; a lit decimal point keeps its digit on).
//  Revision : 1.0  initial release
// ============================================================================
module disp_sevenseg
    import disp_pkg::*;
#(
    parameter int DIGIT_PERIOD = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             hex0,
    input  logic [3:0]             hex1,
    input  logic [3:0]             hex2,
    input  logic [3:0]             hex3,
    input  logic [DIGIT_COUNT-1:0] dp_in,
    output logic [6:0]             sseg,
    output logic                   dp,
    output logic [DIGIT_COUNT-1:0] an,
    output logic                   frame_tick
);

    localparam int PW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;

    // Reject parameter sets that leave no visible time in a slot
    if (DIGIT_PERIOD < 4) begin : g_bad_period
        $error("disp_sevenseg: DIGIT_PERIOD must be >= 4");
    end
    if ((BLANK_CYCLES < 1) || (BLANK_CYCLES >= DIGIT_PERIOD - 1)) begin : g_bad_blank
        $error("disp_sevenseg: BLANK_CYCLES must be in 1 .. DIGIT_PERIOD-2");
    end

    logic [PW-1:0]                prescaler;
    digit_idx_t                   index;
    logic [DIGIT_COUNT-1:0][3:0]  snap_hex;
    logic [DIGIT_COUNT-1:0]       snap_dp;

    logic                         slot_end;
    logic                         frame_start;
    logic                         in_blank;
    logic [3:0]                   cur_hex;
    logic [6:0]                   cur_seg;
    logic [DIGIT_COUNT-1:0]       lz_mask;

    assign slot_end    = (prescaler == PW'(DIGIT_PERIOD - 1));
    assign frame_start = (index == '0) && (prescaler == '0);
    assign in_blank    = (prescaler < PW'(BLANK_CYCLES));
    assign cur_hex     = snap_hex[index];

    // Counters sit at the frame start while held in reset, so gate with rst_n
    assign frame_tick  = rst_n & frame_start;

    // Prescaler and digit index: index advances on prescaler terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            index     <= '0;
        end else if (slot_end) begin
            prescaler <= '0;
            index     <= index + 2'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Frame snapshot of digit values and decimal points
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_hex <= '0;
            snap_dp  <= '0;
        end else if (frame_start) begin
            snap_hex <= {hex3, hex2, hex1, hex0};
            snap_dp  <= dp_in;
        end
    end

    // Leading-zero suppression mask (a digit with its dp lit is never blanked)
    always_comb begin
        lz_mask = '0;
`ifdef DISP_LEADING_ZERO_BLANK_EN
        lz_mask[3] = (snap_hex[3] == 4'h0) && !snap_dp[3];
        lz_mask[2] = (snap_hex[3] == 4'h0) && (snap_hex[2] == 4'h0) && !snap_dp[2];
        lz_mask[1] = (snap_hex[3] == 4'h0) && (snap_hex[2] == 4'h0) &&
                     (snap_hex[1] == 4'h0) && !snap_dp[1];
        lz_mask[0] = 1'b0;
`else
        lz_mask = '0;
`endif
    end

    disp_hex_decoder u_decoder (
        .hex (cur_hex),
        .seg (cur_seg)
    );

    // Registered display drive: blank window or suppressed digit -> all off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an   <= ANODES_OFF;
            sseg <= SEG_OFF;
            dp   <= 1'b1;
        end else if (in_blank || lz_mask[index]) begin
            an   <= ANODES_OFF;
            sseg <= SEG_OFF;
            dp   <= 1'b1;
        end else begin
            an   <= anode_select(index);
            sseg <= cur_seg;
            dp   <= ~snap_dp[index];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_disp_sevenseg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_disp_sevenseg
//  Purpose  : Self-checking bench for disp_sevenseg with DIGIT_PERIOD=8,
//             BLANK_CYCLES=2. Reference model works from the cycle count
//             since reset release (slot = count/8 mod 4, position = count mod 8)
//             and a per-frame copy of the inputs.
//  Options  : DISP_LEADING_ZERO_BLANK_EN changes the model's expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_disp_sevenseg;

    localparam int DP_T  = 8;
    localparam int BLK_T = 2;
    localparam int FRAME = 4 * DP_T;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] hex0  = '0, hex1 = '0, hex2 = '0, hex3 = '0;
    logic [3:0] dp_in = '0;
    logic [6:0] sseg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    disp_sevenseg #(.DIGIT_PERIOD(DP_T), .BLANK_CYCLES(BLK_T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .dp_in      (dp_in),
        .sseg       (sseg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int         cyc;
    logic [3:0] m_hex [4];
    logic [3:0] m_dpb;
    logic [3:0] m_an;
    logic [6:0] m_sseg;
    logic       m_dp;

    function automatic bit lz_blank(input int slot, input logic [3:0] h3, input logic [3:0] h2,
                                    input logic [3:0] h1, input logic [3:0] dpb);
`ifdef DISP_LEADING_ZERO_BLANK_EN
        if (dpb[slot]) return 1'b0;
        case (slot)
            3: return (h3 == 0);
            2: return (h3 == 0) && (h2 == 0);
            1: return (h3 == 0) && (h2 == 0) && (h1 == 0);
            default: return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc    <= 0;
            m_an   <= 4'hF;
            m_sseg <= 7'h7F;
            m_dp   <= 1'b1;
            m_dpb  <= '0;
            for (int i = 0; i < 4; i++) m_hex[i] <= '0;
        end else begin
            int slot, pos;
            slot = (cyc / DP_T) % 4;
            pos  = cyc % DP_T;
            if (pos < BLK_T || lz_blank(slot, m_hex[3], m_hex[2], m_hex[1], m_dpb)) begin
                m_an   <= 4'hF;
                m_sseg <= 7'h7F;
                m_dp   <= 1'b1;
            end else begin
                m_an   <= 4'hF ^ (4'b1 << slot);
                m_sseg <= seg_ref[m_hex[slot]];
                m_dp   <= ~m_dpb[slot];
            end
            if (cyc % FRAME == 0) begin
                m_hex[0] <= hex0; m_hex[1] <= hex1; m_hex[2] <= hex2; m_hex[3] <= hex3;
                m_dpb    <= dp_in;
            end
            cyc <= cyc + 1;
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (an !== 4'hF)       begin errors++; $display("FAIL reset_an got %b want 1111", an); end
        checks++; if (sseg !== 7'h7F)    begin errors++; $display("FAIL reset_sseg got %b want 1111111", sseg); end
        checks++; if (dp !== 1'b1)       begin errors++; $display("FAIL reset_dp got %b want 1", dp); end
        checks++; if (frame_tick !== 0)  begin errors++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (an !== 4'hF || sseg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold an=%b sseg=%b dp=%b tick=%b want off", an, sseg, dp, frame_tick);
            end
        end
    endtask

    task automatic test_scan_basic();
        @(negedge clk);
        {hex3, hex2, hex1, hex0} = {4'h3, 4'h2, 4'h1, 4'h0};
        dp_in = 4'b0000;
        rst_n = 1'b1;
        #1;
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL first_tick got %b want 1", frame_tick); end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            checks++;
            if (an !== m_an || sseg !== m_sseg || dp !== m_dp || frame_tick !== (cyc % FRAME == 0)) begin
                errors++;
                $display("FAIL scan_model c=%0d an=%b/%b sseg=%b/%b dp=%b/%b tick=%b", c, an, m_an, sseg, m_sseg, dp, m_dp, frame_tick);
            end
            if (c <= 2) begin
                checks++; if (an !== 4'b1111) begin errors++; $display("FAIL blank_window c=%0d an=%b want 1111", c, an); end
            end else if (c <= 8) begin
                checks++;
                if (an !== 4'b1110 || sseg !== 7'b1000000) begin
                    errors++; $display("FAIL digit0 c=%0d an=%b sseg=%b want 1110 1000000", c, an, sseg);
                end
            end else if (c >= 11 && c <= 16) begin
                checks++;
                if (an !== 4'b1101 || sseg !== 7'b1111001) begin
                    errors++; $display("FAIL digit1 c=%0d an=%b sseg=%b want 1101 1111001", c, an, sseg);
                end
            end else if (c >= 35) begin
                checks++;
                if (an !== 4'b1110 || sseg !== 7'b0001110) begin
                    errors++; $display("FAIL new_frame_digit0 c=%0d an=%b sseg=%b want 1110 0001110", c, an, sseg);
                end
            end
            if (c == 5) hex0 = 4'hF;
        end
    endtask

    task automatic test_dp();
        int low_cnt = 0;
        dp_in = 4'b0100;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            checks++;
            if (an !== m_an || sseg !== m_sseg || dp !== m_dp) begin
                errors++;
                $display("FAIL dp_model cyc=%0d an=%b/%b sseg=%b/%b dp=%b/%b", cyc, an, m_an, sseg, m_sseg, dp, m_dp);
            end
            if (dp === 1'b0) begin
                low_cnt++;
                checks++;
                if (an !== 4'b1011) begin errors++; $display("FAIL dp_slot an=%b want 1011 when dp low", an); end
            end
        end
        checks++; if (low_cnt < 6) begin errors++; $display("FAIL dp_count got %0d want >=6", low_cnt); end
        dp_in = 4'b0000;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            checks++;
            if (an !== m_an || sseg !== m_sseg || dp !== m_dp || frame_tick !== (cyc % FRAME == 0)) begin
                errors++;
                $display("FAIL random cyc=%0d an=%b/%b sseg=%b/%b dp=%b/%b tick=%b", cyc, an, m_an, sseg, m_sseg, dp, m_dp, frame_tick);
            end
            if ($urandom_range(0, 3) == 0) begin
                hex0 = 4'($urandom); hex1 = 4'($urandom); hex2 = 4'($urandom); hex3 = 4'($urandom);
                dp_in = 4'($urandom);
            end
        end
    endtask

    task automatic test_leading_zero();
        int cnt3 = 0, cnt2 = 0, shown3 = 0;
        {hex3, hex2, hex1, hex0} = {4'h0, 4'h0, 4'h5, 4'h0};
        dp_in = 4'b0000;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checks++;
            if (an !== m_an || sseg !== m_sseg || dp !== m_dp) begin
                errors++;
                $display("FAIL lz_model cyc=%0d an=%b/%b sseg=%b/%b dp=%b/%b", cyc, an, m_an, sseg, m_sseg, dp, m_dp);
            end
            if (c >= 34 && an === 4'b0111) cnt3++;
            if (c >= 34 && an === 4'b1011) cnt2++;
        end
`ifdef DISP_LEADING_ZERO_BLANK_EN
        checks++; if (cnt3 != 0 || cnt2 != 0) begin errors++; $display("FAIL lz_blank d3=%0d d2=%0d want 0 0", cnt3, cnt2); end
`else
        checks++; if (cnt3 < 6 || cnt2 < 6) begin errors++; $display("FAIL lz_driven d3=%0d d2=%0d want >=6", cnt3, cnt2); end
`endif
        dp_in = 4'b1000;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            checks++;
            if (an !== m_an || sseg !== m_sseg || dp !== m_dp) begin
                errors++;
                $display("FAIL lz_dp_model cyc=%0d an=%b/%b sseg=%b/%b dp=%b/%b", cyc, an, m_an, sseg, m_sseg, dp, m_dp);
            end
            if (an === 4'b0111 && sseg === 7'b1000000) shown3++;
        end
        checks++; if (shown3 < 6) begin errors++; $display("FAIL lz_dp_override d3_shown=%0d want >=6", shown3); end
        dp_in = 4'b0000;
    endtask

    task automatic test_async_reset();
        bit found = 0;
        for (int c = 0; c < 64 && !found; c++) begin
            @(posedge clk); #1;
            if ((cyc / DP_T) % 4 == 2 && cyc % DP_T == 4) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL reset_wait slot2 not reached got 0 want 1"); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF || sseg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset an=%b sseg=%b dp=%b tick=%b want off", an, sseg, dp, frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL restart_tick got %b want 1", frame_tick); end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            checks++;
            if (an !== m_an || sseg !== m_sseg || dp !== m_dp || frame_tick !== (cyc % FRAME == 0)) begin
                errors++;
                $display("FAIL restart_model c=%0d an=%b/%b sseg=%b/%b tick=%b", c, an, m_an, sseg, m_sseg, frame_tick);
            end
            if (c == 3) begin
                checks++; if (an !== 4'b1110) begin errors++; $display("FAIL restart_digit0 an=%b want 1110", an); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_basic();
        test_dp();
        test_random();
        test_leading_zero();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/disp_sevenseg.md
DISP_SEVENSEG -- requirements
Module: disp_sevenseg

Interface
REQ-001 Parameter: DIGIT_PERIOD, 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range >= 4.
REQ-002 Parameter: BLANK_CYCLES, 1000, anti-ghosting cycles at the start of each slot with all anodes off; legal range 1 .. DIGIT_PERIOD-2.
REQ-003 Port: clk  input  1  system clock; the only clock.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: hex0, hex1, hex2, hex3  input  4 each  digit values 0x0-0xF; hex0 is the rightmost digit.
REQ-006 Port: dp_in  input  4  decimal point request per digit; bit i belongs to digit i; 1 = lit.
REQ-007 Port: sseg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
REQ-008 Port: dp  output  1  decimal point cathode, active-low.
REQ-009 Port: an  output  4  digit anodes, active-low; bit i drives digit i.
REQ-010 Port: frame_tick  output  1  one-cycle pulse when a new input snapshot is taken.

Function
REQ-011 Prescaler SHALL count 0..DIGIT_PERIOD-1 and wrap to 0; at its terminal count the digit index SHALL advance 0->1->2->3->0.
REQ-012 Snapshot registers SHALL capture hex0-3 and dp_in in every cycle with index==0 and prescaler==0, including the first cycle after reset release; frame_tick SHALL be 1 in exactly those cycles.
REQ-013 Input changes between snapshots SHALL NOT affect the outputs until the next snapshot (no tearing within a frame).
REQ-014 For prescaler < BLANK_CYCLES: an SHALL be 4'b1111, sseg 7'h7F, dp 1.
REQ-015 Otherwise: an SHALL have only bit[index] low; sseg SHALL be the decoded snapshot digit[index]; dp SHALL be ~snapshot dp[index].
REQ-016 Decode SHALL be standard hex: 0->7'b1000000, 1->7'b1111001, 8->7'b0000000, A->7'b0001000, F->7'b0001110; remaining codes per the usual table.
REQ-017 an, sseg and dp SHALL be registered; they reflect the prescaler/index/snapshot state of the previous cycle (latency 1 clk).
REQ-018 frame_tick SHALL be combinational from the counter state (same cycle as the capture).

Reset
REQ-019 While rst_n==0: prescaler=0, index=0, snapshot=0, an=4'hF, sseg=7'h7F, dp=1, frame_tick=0. This SHALL take effect immediately, independent of clk.
REQ-020 Reset asserted mid-slot or mid-frame SHALL abort the scan; after release, scanning SHALL restart at digit 0 with a fresh snapshot.

Configuration
REQ-021 Macro DISP_LEADING_ZERO_BLANK_EN: when defined, digit 3 SHALL be blanked (its anode held 1) if its snapshot is 0. Digit 2 SHALL be blanked if digits 3 and 2 are both 0. Digit 1 SHALL be blanked if digits 3, 2 and 1 are all 0. Digit 0 is never blanked.
REQ-022 Leading-zero blanking SHALL be ignored for any digit whose snapshot dp bit is 1.
REQ-023 Without DISP_LEADING_ZERO_BLANK_EN, all four digits SHALL always be driven.

Structure
REQ-024 Package disp_pkg SHALL hold: the digit count constant (4), the segment-pattern constants for 0x0-0xF, and the SEG_OFF constant (7'h7F).
REQ-025 Sub-module disp_hex_decoder (combinational, 4-bit in, 7-bit out) SHALL perform the REQ-016 mapping.
REQ-026 Elaboration SHALL fail if BLANK_CYCLES >= DIGIT_PERIOD-1.

Verification (DIGIT_PERIOD=8, BLANK_CYCLES=2)
REQ-027 Hold rst_n=0 -> an=1111, sseg=1111111, dp=1, frame_tick=0, with no clock edge needed.
REQ-028 Release reset with hex3..0={3,2,1,0}, dp_in=0 -> frame_tick=1 in cycle 0. Cycles 1-2: an=1111. Cycles 3-8: an=1110, sseg=1000000. The next slot shows an=1101, sseg=1111001.
REQ-029 Change hex0 from 0 to F in cycle 5 -> digit 0 still shows 1000000 until the next frame_tick, then shows 0001110.
REQ-030 dp_in=4'b0100 -> dp=0 only during the active cycles of the digit-2 slot.
REQ-031 With the macro defined, hex3..0={0,0,5,0} -> an never shows 0111 or 1011; digits 1 and 0 display normally. Then set dp_in[3]=1 -> digit 3 is driven and shows 1000000.
REQ-032 Pulse rst_n low during the digit-2 slot -> outputs go off immediately. After release, the scan restarts at digit 0 with frame_tick=1 in the first cycle.
